// File: rtl/fp16_div_pkg.sv
// Shared types and constants for the sequential FP16 divider.
// State encoding, field widths and special-operand helpers.
package fp16_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_RND  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;
  localparam int ITER_CNT = 13;
  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int MANT_W   = FRAC_W + 1;
  localparam int QUO_W    = ITER_CNT;
  localparam int CNT_W    = 4;

  localparam logic [EXP_W-1:0] EXP_ALL1 = EXP_W'(EXP_MAX);
  localparam logic [14:0]      MAG_INF  = 15'h7C00;
  localparam logic [14:0]      MAG_ZERO = 15'h0000;

  // Zero/subnormal and inf/NaN exponents bypass the divider entirely.
  function automatic logic is_special(input logic [EXP_W-1:0] ea, input logic [EXP_W-1:0] eb);
    return (ea == '0) || (ea == EXP_ALL1) || (eb == '0) || (eb == EXP_ALL1);
  endfunction

  function automatic logic [14:0] special_mag(input logic [EXP_W-1:0] ea, input logic [EXP_W-1:0] eb);
    if ((eb == '0) || (ea == EXP_ALL1)) begin
      return MAG_INF;
    end
    return MAG_ZERO;
  endfunction

endpackage

// File: rtl/fp16_div_seq_if.sv
// Operand/result handshake bundle for fp16_div_seq; status[3:0] exists only
// when FP16_DIV_STATUS_EN is defined.
interface fp16_div_seq_if;
  logic [15:0] a;
  logic [15:0] b;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic        out_valid;
  logic        out_ready;
`ifdef FP16_DIV_STATUS_EN
  logic [3:0]  status;
`endif

  modport master (
    output a, b, in_valid, out_ready,
`ifdef FP16_DIV_STATUS_EN
    input  status,
`endif
    input  in_ready, x, out_valid
  );

  modport slave (
    input  a, b, in_valid, out_ready,
`ifdef FP16_DIV_STATUS_EN
    output status,
`endif
    output in_ready, x, out_valid
  );
endinterface

// File: rtl/fp16_div_round.sv
// Combinational normalize, round-to-nearest-even and overflow/underflow
// clamp of the restoring-division quotient; result magnitude excludes sign.
module fp16_div_round
  import fp16_div_pkg::*;
(
  input  logic [QUO_W-1:0] quo,
  input  logic             rem_nz,
  input  logic [EXP_W-1:0] ea,
  input  logic [EXP_W-1:0] eb,
  output logic [14:0]      mag,
  output logic             ovf,
  output logic             unf
);

  localparam logic signed [6:0] BIAS_S = 7'(EXP_BIAS);
  localparam logic signed [6:0] MAX_S  = 7'(EXP_MAX);

  logic [FRAC_W-1:0] mant;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic [FRAC_W:0]   mant_r;
  logic signed [6:0] adj;
  logic signed [6:0] exp_s;
  logic signed [6:0] exp_f;

  always_comb begin
    // Quotient lies in (2^11, 2^13): the top bit picks the normalization.
    if (quo[QUO_W-1]) begin
      mant   = quo[11:2];
      guard  = quo[1];
      sticky = quo[0] | rem_nz;
      adj    = 7'sd0;
    end else begin
      mant   = quo[10:1];
      guard  = quo[0];
      sticky = rem_nz;
      adj    = -7'sd1;
    end
    exp_s  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S + adj;
    inc    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {{FRAC_W{1'b0}}, inc};
    exp_f  = exp_s + (mant_r[FRAC_W] ? 7'sd1 : 7'sd0);
    ovf    = (exp_f >= MAX_S);
    unf    = (exp_f <= 7'sd0);
    if (ovf) begin
      mag = MAG_INF;
    end else if (unf) begin
      mag = MAG_ZERO;
    end else begin
      mag = {exp_f[4:0], mant_r[FRAC_W-1:0]};
    end
  end

endmodule

// File: rtl/fp16_div_seq.sv
// Sequential FP16 divider: 14-cycle latency (normal), 1 cycle (special); holds
// result until out_ready. Optional status[3:0] under FP16_DIV_STATUS_EN.
module fp16_div_seq
  import fp16_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fp16_div_seq_if.slave io
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MANT_W-1:0]   mb_q, mb_d;
  logic [MANT_W-1:0]   rem_q, rem_d;
  logic [QUO_W-1:0]    quo_q, quo_d;
  logic [EXP_W-1:0]    ea_q, ea_d;
  logic [EXP_W-1:0]    eb_q, eb_d;
  logic                sign_q, sign_d;
  logic [15:0]         x_q, x_d;
`ifdef FP16_DIV_STATUS_EN
  logic [3:0]          status_q, status_d;
  logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                invalid, div_by_zero;
`endif

  logic [EXP_W-1:0]    a_exp, b_exp;
  logic [MANT_W-1:0]   ma_in, mb_in;
  logic                accept, special, in_sign;
  logic                first_ge;
  logic [MANT_W-1:0]   first_rem;
  logic [MANT_W:0]     r_sh, r_diff;
  logic                step_ge;
  logic [14:0]         rnd_mag;
  logic                rnd_ovf, rnd_unf;

  assign a_exp     = io.a[14:10];
  assign b_exp     = io.b[14:10];
  assign ma_in     = {1'b1, io.a[FRAC_W-1:0]};
  assign mb_in     = {1'b1, io.b[FRAC_W-1:0]};
  assign in_sign   = io.a[15] ^ io.b[15];
  assign special   = is_special(a_exp, b_exp);
  assign accept    = io.in_valid & io.in_ready;

  // First quotient bit is resolved on the accept edge itself.
  assign first_ge  = (ma_in >= mb_in);
  assign first_rem = first_ge ? (ma_in - mb_in) : ma_in;

  assign r_sh      = {rem_q, 1'b0};
  assign step_ge   = (r_sh >= {1'b0, mb_q});
  assign r_diff    = step_ge ? (r_sh - {1'b0, mb_q}) : r_sh;

`ifdef FP16_DIV_STATUS_EN
  assign a_nan       = (a_exp == EXP_ALL1) && (io.a[FRAC_W-1:0] != '0);
  assign b_nan       = (b_exp == EXP_ALL1) && (io.b[FRAC_W-1:0] != '0);
  assign a_inf       = (a_exp == EXP_ALL1) && (io.a[FRAC_W-1:0] == '0);
  assign b_inf       = (b_exp == EXP_ALL1) && (io.b[FRAC_W-1:0] == '0);
  assign a_zero      = (a_exp == '0);
  assign b_zero      = (b_exp == '0);
  assign invalid     = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
  assign div_by_zero = b_zero & ~a_zero & (a_exp != EXP_ALL1);
`endif

  fp16_div_round u_round (
    .quo    (quo_q),
    .rem_nz (rem_q != '0),
    .ea     (ea_q),
    .eb     (eb_q),
    .mag    (rnd_mag),
    .ovf    (rnd_ovf),
    .unf    (rnd_unf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_DIV;
      ST_DIV:  if (cnt_q == CNT_W'(ITER_CNT - 1)) state_d = ST_RND;
      ST_RND:  state_d = ST_DONE;
      ST_DONE: if (io.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = (state_q == ST_IDLE);
    io.out_valid = (state_q == ST_DONE);
    io.x         = x_q;
`ifdef FP16_DIV_STATUS_EN
    io.status    = status_q;
`endif
  end

  always_comb begin
    cnt_d    = cnt_q;
    mb_d     = mb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    sign_d   = sign_q;
    x_d      = x_q;
`ifdef FP16_DIV_STATUS_EN
    status_d = status_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sign_d = in_sign;
          ea_d   = a_exp;
          eb_d   = b_exp;
          mb_d   = mb_in;
          rem_d  = first_rem;
          quo_d  = {{(QUO_W-1){1'b0}}, first_ge};
          cnt_d  = CNT_W'(1);
          if (special) begin
            x_d = {in_sign, special_mag(a_exp, b_exp)};
`ifdef FP16_DIV_STATUS_EN
            status_d = {div_by_zero, invalid, 2'b00};
`endif
          end
        end
      end
      ST_DIV: begin
        quo_d = {quo_q[QUO_W-2:0], step_ge};
        rem_d = r_diff[MANT_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_RND: begin
        x_d = {sign_q, rnd_mag};
`ifdef FP16_DIV_STATUS_EN
        status_d = {2'b00, rnd_ovf, rnd_unf};
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      mb_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      ea_q     <= '0;
      eb_q     <= '0;
      sign_q   <= 1'b0;
      x_q      <= '0;
`ifdef FP16_DIV_STATUS_EN
      status_q <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      mb_q     <= mb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      sign_q   <= sign_d;
      x_q      <= x_d;
`ifdef FP16_DIV_STATUS_EN
      status_q <= status_d;
`endif
    end
  end

`ifndef FP16_DIV_STATUS_EN
  // Flags are only consumed by the status build.
  logic unused_flags;
  assign unused_flags = rnd_ovf ^ rnd_unf;
`endif

endmodule

// File: tb/tb_fp16_div_seq.sv
// Directed-vector bench for fp16_div_seq: results, latency, hold, reset abort.
// Status checks are compiled in when FP16_DIV_STATUS_EN is defined.
module tb_fp16_div_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp16_div_seq_if dut_if ();

  fp16_div_seq dut (
    .clk (clk),
    .rst (rst),
    .io  (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] av, input logic [15:0] bv);
    int n;
    n = 0;
    while (!dut_if.in_ready && n < 50) begin
      tick();
      n++;
    end
    dut_if.a        = av;
    dut_if.b        = bv;
    dut_if.in_valid = 1'b1;
    tick();
    dut_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!dut_if.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic retire(input string tag);
    dut_if.out_ready = 1'b1;
    tick();
    dut_if.out_ready = 1'b0;
    check({tag, "_ovld_after"}, {31'd0, dut_if.out_valid}, 32'd0);
    check({tag, "_rdy_after"}, {31'd0, dut_if.in_ready}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] exp_x, input int exp_lat, input logic [3:0] exp_st);
    int lat;
    start(av, bv);
    wait_done(1, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_x"}, {16'd0, dut_if.x}, {16'd0, exp_x});
`ifdef FP16_DIV_STATUS_EN
    check({tag, "_status"}, {28'd0, dut_if.status}, {28'd0, exp_st});
`else
    if (exp_st === 4'hx) $display("note: unexpected status literal");
`endif
    retire(tag);
  endtask

  initial begin
    int lat;
    checks           = 0;
    errors           = 0;
    rst              = 1'b0;
    dut_if.a         = 16'h0000;
    dut_if.b         = 16'h0000;
    dut_if.in_valid  = 1'b0;
    dut_if.out_ready = 1'b0;
    repeat (3) tick();

    check("reset_x", {16'd0, dut_if.x}, 32'h0000);
    check("reset_out_valid", {31'd0, dut_if.out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, dut_if.in_ready}, 32'd1);
`ifdef FP16_DIV_STATUS_EN
    check("reset_status", {28'd0, dut_if.status}, 32'd0);
`endif
    rst = 1'b1;
    tick();

    do_op("one_div_one", 16'h3C00, 16'h3C00, 16'h3C00, 14, 4'b0000);
    do_op("one_div_three", 16'h3C00, 16'h4200, 16'h3555, 14, 4'b0000);
    do_op("round_up", 16'h3C01, 16'h4200, 16'h3557, 14, 4'b0000);
    do_op("neg_sign", 16'h4600, 16'hC000, 16'hC200, 14, 4'b0000);
    do_op("one_div_1p5", 16'h3C00, 16'h3E00, 16'h3955, 14, 4'b0000);
    do_op("div_by_zero", 16'h3C00, 16'h0000, 16'h7C00, 1, 4'b1000);
    do_op("zero_div_inf", 16'h0000, 16'h7C00, 16'h0000, 1, 4'b0000);
    do_op("zero_div_zero", 16'h8000, 16'h0000, 16'hFC00, 1, 4'b0100);
    do_op("nan_clamp", 16'h7E00, 16'h3C00, 16'h7C00, 1, 4'b0100);
    do_op("overflow", 16'h7BFF, 16'h0400, 16'h7C00, 14, 4'b0010);
    do_op("underflow", 16'h0400, 16'h7BFF, 16'h0000, 14, 4'b0001);

    // in_valid pulse during DIV must be ignored; result then held in DONE.
    start(16'h3C00, 16'h4200);
    tick();
    dut_if.a        = 16'h4000;
    dut_if.b        = 16'h3C00;
    dut_if.in_valid = 1'b1;
    check("busy_in_ready", {31'd0, dut_if.in_ready}, 32'd0);
    tick();
    dut_if.in_valid = 1'b0;
    wait_done(3, lat);
    check("busy_lat", lat, 14);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_x", i), {16'd0, dut_if.x}, 32'h3555);
      check($sformatf("hold%0d_ovld", i), {31'd0, dut_if.out_valid}, 32'd1);
      check($sformatf("hold%0d_rdy", i), {31'd0, dut_if.in_ready}, 32'd0);
      tick();
    end
    retire("hold");

    // Reset during the sixth DIV iteration aborts the operation.
    start(16'h3C00, 16'h3C00);
    repeat (5) tick();
    check("pre_abort_ovld", {31'd0, dut_if.out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort_x", {16'd0, dut_if.x}, 32'h0000);
    check("abort_ovld", {31'd0, dut_if.out_valid}, 32'd0);
    check("abort_rdy", {31'd0, dut_if.in_ready}, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("post_abort_ovld", {31'd0, dut_if.out_valid}, 32'd0);
    do_op("after_reset", 16'h3C00, 16'h3C00, 16'h3C00, 14, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
